// File: rtl/floo_dma_job_sched.sv
// -----------------------------------------------------------------------------
// floo_dma_job_sched
//
// Round-robin scheduler that collects DMA jobs from NumReq requesters and
// issues them one at a time to a single DMA backend through a registered
// output stage. Job ownership is tracked in an in-order FIFO so that each
// backend completion (be_done_i) is routed back to the requester that
// submitted the job, as a one-cycle done_o pulse.
//
// Optional feature: define FLOO_DMA_SCHED_STATS_EN to add grant_cnt_o, a set
// of per-requester 16-bit saturating grant counters.
//
// Reset is synchronous and active-low (rst_ni).
// -----------------------------------------------------------------------------
module floo_dma_job_sched #(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned LenWidth    = 32,
  parameter int unsigned MaxInflight = 4,
  localparam int unsigned IdxW = $clog2(NumReq),
  localparam int unsigned CntW = $clog2(MaxInflight + 1),
  localparam int unsigned PtrW = (MaxInflight > 1) ? $clog2(MaxInflight) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // Requester side
  input  logic [NumReq-1:0]             job_valid_i,
  output logic [NumReq-1:0]             job_ready_o,
  input  logic [NumReq*AddrWidth-1:0]   job_src_i,
  input  logic [NumReq*AddrWidth-1:0]   job_dst_i,
  input  logic [NumReq*LenWidth-1:0]    job_len_i,
  // Backend side
  output logic                          be_valid_o,
  input  logic                          be_ready_i,
  output logic [AddrWidth-1:0]          be_src_o,
  output logic [AddrWidth-1:0]          be_dst_o,
  output logic [LenWidth-1:0]           be_len_o,
  input  logic                          be_done_i,
  // Completion and status
  output logic [NumReq-1:0]             done_o,
  output logic [CntW-1:0]               inflight_o,
  output logic                          err_o
`ifdef FLOO_DMA_SCHED_STATS_EN
  ,
  output logic [NumReq*16-1:0]          grant_cnt_o
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IdxW-1:0]      rr_ptr_q;
  logic [CntW-1:0]      inflight_q;
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [IdxW-1:0]      owner_q [MaxInflight];
  logic                 be_valid_q;
  logic [AddrWidth-1:0] be_src_q;
  logic [AddrWidth-1:0] be_dst_q;
  logic [LenWidth-1:0]  be_len_q;
  logic [NumReq-1:0]    done_q;
  logic                 err_q;

  // ---------------------------------------------------------------------------
  // Combinational decisions
  // ---------------------------------------------------------------------------
  logic                 grant_valid;
  logic [IdxW-1:0]      grant_idx;
  logic                 can_accept;
  logic                 accept;
  logic                 done_valid;
  logic [AddrWidth-1:0] sel_src;
  logic [AddrWidth-1:0] sel_dst;
  logic [LenWidth-1:0]  sel_len;

  // A slot released by be_done_i only becomes visible through inflight_q on
  // the next cycle, so the registered count alone gates acceptance.
  assign can_accept = rst_ni
                    && (inflight_q < CntW'(MaxInflight))
                    && (!be_valid_q || be_ready_i);
  assign accept     = can_accept && grant_valid;

  // A completion with nothing outstanding is a protocol error and is dropped.
  assign done_valid = be_done_i && (inflight_q != '0);

  // Round-robin search starting at rr_ptr_q; the lowest offset wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((int'(rr_ptr_q) + k) % int'(NumReq));
      if (job_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // One-hot accept to the winner; all-zero whenever acceptance is blocked.
  always_comb begin
    job_ready_o = '0;
    if (accept) begin
      job_ready_o[grant_idx] = 1'b1;
    end
  end

  // Pick the winner's job fields out of the flattened request buses.
  always_comb begin
    sel_src = job_src_i[32'(grant_idx)*AddrWidth +: AddrWidth];
    sel_dst = job_dst_i[32'(grant_idx)*AddrWidth +: AddrWidth];
    sel_len = job_len_i[32'(grant_idx)*LenWidth  +: LenWidth];
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Priority pointer moves to the slot after the most recent winner.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (accept) begin
      rr_ptr_q <= (grant_idx == IdxW'(NumReq - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // Issue stage: load on acceptance, hold while stalled, drain on handoff.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      be_valid_q <= 1'b0;
      be_src_q   <= '0;
      be_dst_q   <= '0;
      be_len_q   <= '0;
    end else if (accept) begin
      be_valid_q <= 1'b1;
      be_src_q   <= sel_src;
      be_dst_q   <= sel_dst;
      be_len_q   <= sel_len;
    end else if (be_ready_i) begin
      be_valid_q <= 1'b0;
    end
  end

  // Ownership FIFO storage: written at the tail on every acceptance.
  always_ff @(posedge clk_i) begin
    // NOTE: the storage array is deliberately left out of reset; an entry is
    // only read after it has been written, and the pointers are reset.
    if (accept) begin
      owner_q[wr_ptr_q] <= grant_idx;
    end
  end

  // FIFO pointers wrap at MaxInflight, which need not be a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (accept) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(MaxInflight - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (done_valid) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxInflight - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // Outstanding-job counter; a simultaneous accept and completion cancel.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      case ({accept, done_valid})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Completion pulse to the owner at the FIFO head, one cycle after be_done_i.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      done_q <= '0;
    end else begin
      done_q <= '0;
      if (done_valid) begin
        done_q[owner_q[rd_ptr_q]] <= 1'b1;
      end
    end
  end

  // Sticky error on a completion that has no outstanding job.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (be_done_i && (inflight_q == '0)) begin
      err_q <= 1'b1;
    end
  end

`ifdef FLOO_DMA_SCHED_STATS_EN
  logic [15:0] grant_cnt_q [NumReq];

  // Per-requester grant counters that stop at 16'hFFFF.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumReq); i++) begin
        grant_cnt_q[i] <= '0;
      end
    end else if (accept && (grant_cnt_q[grant_idx] != 16'hFFFF)) begin
      grant_cnt_q[grant_idx] <= grant_cnt_q[grant_idx] + 16'd1;
    end
  end

  // Flatten the counters; requester i occupies slice i.
  always_comb begin
    grant_cnt_o = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      grant_cnt_o[i*16 +: 16] = grant_cnt_q[i];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign be_valid_o = be_valid_q;
  assign be_src_o   = be_src_q;
  assign be_dst_o   = be_dst_q;
  assign be_len_o   = be_len_q;
  assign done_o     = done_q;
  assign inflight_o = inflight_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_floo_dma_job_sched.sv
// -----------------------------------------------------------------------------
// tb_floo_dma_job_sched
//
// Directed bench for floo_dma_job_sched with default parameters
// (NumReq=2, MaxInflight=4). Inputs change on the falling edge; outputs are
// compared 1 time unit later, so combinational job_ready_o reflects the new
// inputs and registered outputs reflect the last rising edge.
// With FLOO_DMA_SCHED_STATS_EN defined the grant-counter saturation case runs.
// -----------------------------------------------------------------------------
module tb_floo_dma_job_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  job_valid_i;
  logic [1:0]  job_ready_o;
  logic [63:0] job_src_i;
  logic [63:0] job_dst_i;
  logic [63:0] job_len_i;
  logic        be_valid_o;
  logic        be_ready_i;
  logic [31:0] be_src_o;
  logic [31:0] be_dst_o;
  logic [31:0] be_len_o;
  logic        be_done_i;
  logic [1:0]  done_o;
  logic [2:0]  inflight_o;
  logic        err_o;
`ifdef FLOO_DMA_SCHED_STATS_EN
  logic [31:0] grant_cnt_o;
`endif

  logic [31:0] src [2];
  logic [31:0] dst [2];
  logic [31:0] len [2];

  assign job_src_i = {src[1], src[0]};
  assign job_dst_i = {dst[1], dst[0]};
  assign job_len_i = {len[1], len[0]};

  floo_dma_job_sched dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .job_valid_i (job_valid_i),
    .job_ready_o (job_ready_o),
    .job_src_i   (job_src_i),
    .job_dst_i   (job_dst_i),
    .job_len_i   (job_len_i),
    .be_valid_o  (be_valid_o),
    .be_ready_i  (be_ready_i),
    .be_src_o    (be_src_o),
    .be_dst_o    (be_dst_o),
    .be_len_o    (be_len_o),
    .be_done_i   (be_done_i),
    .done_o      (done_o),
    .inflight_o  (inflight_o),
    .err_o       (err_o)
`ifdef FLOO_DMA_SCHED_STATS_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one full cycle: rising edge, then back to the falling edge, then
  // let combinational logic settle.
  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic default_fields();
    src[0] = 32'hA000_0000; dst[0] = 32'hD000_0000; len[0] = 32'h0000_0100;
    src[1] = 32'hA000_0001; dst[1] = 32'hD000_0001; len[1] = 32'h0000_0101;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni      = 1'b0;
    job_valid_i = 2'b00;
    be_ready_i  = 1'b0;
    be_done_i   = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [1:0] valid;
    logic       be_ready;
    logic       be_done;
    logic [1:0] exp_ready;
    logic       exp_be_valid;
    int         exp_src_req;
    logic [2:0] exp_inflight;
    logic [1:0] exp_done;
  } vec_t;

  vec_t vecs [9];

  // Hang guard: any stall in the sequencing below ends the run here.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected normal completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Both requesters always valid, backend always ready, be_done_i two
    // cycles after each handoff: grants alternate 0,1,0,1 and done_o follows.
    //            valid  rdy  done  ready  bv  src  infl  done_o
    vecs[0] = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 0, 3'd0, 2'b00};
    vecs[1] = '{2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 0, 3'd1, 2'b00};
    vecs[2] = '{2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 1, 3'd2, 2'b00};
    vecs[3] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 0, 3'd3, 2'b00};
    vecs[4] = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 1, 3'd3, 2'b01};
    vecs[5] = '{2'b11, 1'b1, 1'b1, 2'b10, 1'b1, 0, 3'd3, 2'b10};
    vecs[6] = '{2'b11, 1'b1, 1'b1, 2'b01, 1'b1, 1, 3'd3, 2'b01};
    vecs[7] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b1, 0, 3'd3, 2'b10};
    vecs[8] = '{2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 0, 3'd3, 2'b00};

    default_fields();
    rst_ni      = 1'b0;
    job_valid_i = 2'b11;
    be_ready_i  = 1'b1;
    be_done_i   = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk_i);
    settle();
    check("rst_job_ready", 64'(job_ready_o), 64'd0);
    tick();
    tick();
    settle();
    check("rst_job_ready2", 64'(job_ready_o), 64'd0);
    check("rst_be_valid",   64'(be_valid_o),  64'd0);
    check("rst_be_src",     64'(be_src_o),    64'd0);
    check("rst_inflight",   64'(inflight_o),  64'd0);
    check("rst_done",       64'(done_o),      64'd0);
    check("rst_err",        64'(err_o),       64'd0);

    // ---------------- table: round-robin alternation ----------------
    do_reset();
    for (int i = 0; i < 9; i++) begin
      job_valid_i = vecs[i].valid;
      be_ready_i  = vecs[i].be_ready;
      be_done_i   = vecs[i].be_done;
      settle();
      check($sformatf("rr[%0d].job_ready", i), 64'(job_ready_o), 64'(vecs[i].exp_ready));
      check($sformatf("rr[%0d].be_valid", i),  64'(be_valid_o),  64'(vecs[i].exp_be_valid));
      if (vecs[i].exp_be_valid) begin
        check($sformatf("rr[%0d].be_src", i), 64'(be_src_o), 64'(src[vecs[i].exp_src_req]));
        check($sformatf("rr[%0d].be_len", i), 64'(be_len_o), 64'(len[vecs[i].exp_src_req]));
      end
      check($sformatf("rr[%0d].inflight", i), 64'(inflight_o), 64'(vecs[i].exp_inflight));
      check($sformatf("rr[%0d].done", i),     64'(done_o),     64'(vecs[i].exp_done));
      check($sformatf("rr[%0d].err", i),      64'(err_o),      64'd0);
      tick();
    end

    // ---------------- inflight limit and slot release timing ----------------
    do_reset();
    job_valid_i = 2'b01;
    be_ready_i  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("lim.accept%0d", k), 64'(job_ready_o), 64'b01);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      settle();
      check($sformatf("lim.full_ready%0d", k), 64'(job_ready_o), 64'b00);
      check($sformatf("lim.full_infl%0d", k),  64'(inflight_o),  64'd4);
      tick();
    end
    be_done_i = 1'b1;
    settle();
    check("lim.ready_same_cycle_as_done", 64'(job_ready_o), 64'b00);
    tick();
    be_done_i = 1'b0;
    settle();
    check("lim.done_pulse",       64'(done_o),      64'b01);
    check("lim.infl_after_done",  64'(inflight_o),  64'd3);
    check("lim.fifth_accept",     64'(job_ready_o), 64'b01);
    tick();
    settle();
    check("lim.refull_ready",     64'(job_ready_o), 64'b00);
    check("lim.refull_infl",      64'(inflight_o),  64'd4);
    check("lim.done_cleared",     64'(done_o),      64'b00);
    job_valid_i = 2'b00;

    // ---------------- backend stall holds fields ----------------
    do_reset();
    src[0] = 32'h0000_1000; dst[0] = 32'h0000_2000; len[0] = 32'h0000_0040;
    job_valid_i = 2'b01;
    be_ready_i  = 1'b0;
    settle();
    check("stall.first_accept", 64'(job_ready_o), 64'b01);
    tick();
    src[0] = 32'hDEAD_0000; dst[0] = 32'hDEAD_1111; len[0] = 32'h0;
    for (int k = 0; k < 10; k++) begin
      settle();
      check($sformatf("stall[%0d].be_valid", k), 64'(be_valid_o),  64'd1);
      check($sformatf("stall[%0d].be_src", k),   64'(be_src_o),    64'h1000);
      check($sformatf("stall[%0d].be_dst", k),   64'(be_dst_o),    64'h2000);
      check($sformatf("stall[%0d].be_len", k),   64'(be_len_o),    64'h40);
      check($sformatf("stall[%0d].ready", k),    64'(job_ready_o), 64'b00);
      tick();
    end
    settle();
    check("stall.inflight", 64'(inflight_o), 64'd1);
    be_ready_i = 1'b1;
    settle();
    check("stall.handoff_accept", 64'(job_ready_o), 64'b01);
    tick();
    job_valid_i = 2'b00;
    settle();
    check("stall.zero_len_valid", 64'(be_valid_o), 64'd1);
    check("stall.zero_len_src",   64'(be_src_o),   64'hDEAD_0000);
    check("stall.zero_len_len",   64'(be_len_o),   64'h0);
    check("stall.inflight2",      64'(inflight_o), 64'd2);
    default_fields();

    // ---------------- accept and complete in the same cycle ----------------
    do_reset();
    job_valid_i = 2'b10;
    be_ready_i  = 1'b1;
    settle();
    check("same.acc_r1_a", 64'(job_ready_o), 64'b10);
    tick();
    settle();
    check("same.acc_r1_b", 64'(job_ready_o), 64'b10);
    tick();
    job_valid_i = 2'b01;
    be_done_i   = 1'b1;
    settle();
    check("same.infl_before", 64'(inflight_o),  64'd2);
    check("same.acc_r0",      64'(job_ready_o), 64'b01);
    tick();
    job_valid_i = 2'b00;
    be_done_i   = 1'b0;
    settle();
    check("same.infl_after",  64'(inflight_o), 64'd2);
    check("same.done_head",   64'(done_o),     64'b10);
    check("same.err",         64'(err_o),      64'd0);

    // ------- reset mid-operation, then a stale completion is an error -------
    do_reset();
    settle();
    check("stale.infl_reset", 64'(inflight_o), 64'd0);
    check("stale.bv_reset",   64'(be_valid_o), 64'd0);
    be_done_i = 1'b1;
    settle();
    check("stale.err_before", 64'(err_o), 64'd0);
    tick();
    be_done_i = 1'b0;
    settle();
    check("stale.err_set",   64'(err_o),      64'd1);
    check("stale.no_done",   64'(done_o),     64'b00);
    check("stale.infl_zero", 64'(inflight_o), 64'd0);
    for (int k = 0; k < 3; k++) tick();
    job_valid_i = 2'b01;
    be_ready_i  = 1'b1;
    tick();
    job_valid_i = 2'b00;
    settle();
    check("stale.err_sticky", 64'(err_o),      64'd1);
    check("stale.after_acc",  64'(inflight_o), 64'd1);

`ifdef FLOO_DMA_SCHED_STATS_EN
    // ---------------- grant counter saturation ----------------
    do_reset();
    job_valid_i = 2'b10;
    be_ready_i  = 1'b1;
    tick();
    be_done_i = 1'b1;
    for (int k = 1; k < 70000; k++) tick();
    job_valid_i = 2'b00;
    be_done_i   = 1'b0;
    tick();
    settle();
    check("stats.req1_sat", 64'(grant_cnt_o[31:16]), 64'hFFFF);
    check("stats.req0_zero", 64'(grant_cnt_o[15:0]), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
